// File: rtl/hand_tracker.sv
// rtl/hand_tracker.sv - Blackjack hand tracker: routes dealt cards into player/dealer hands,
// keeps soft-ace totals and status flags, and settles the round into a registered outcome.
module hand_tracker (
  input  logic       clk,
  input  logic       reset,
  input  logic       card_valid,
  input  logic [3:0] card_value,
  input  logic       to_dealer,
  input  logic       settle,
  input  logic       new_round,
  output logic [4:0] player_score,
  output logic [4:0] dealer_score,
  output logic       player_soft,
  output logic       dealer_soft,
  output logic       player_bust,
  output logic       dealer_bust,
  output logic       player_bj,
  output logic       dealer_bj,
  output logic [3:0] player_cards,
  output logic [3:0] dealer_cards,
  output logic       dealer_must_hit,
  output logic [1:0] outcome,
  output logic       outcome_valid,
  output logic       card_err
);

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] OUT_NONE   = 2'd0;
  localparam logic [1:0] OUT_PLAYER = 2'd1;
  localparam logic [1:0] OUT_DEALER = 2'd2;
  localparam logic [1:0] OUT_PUSH   = 2'd3;

  state_t     state_q, state_d;
  logic [4:0] p_hard_q, p_hard_d, d_hard_q, d_hard_d;
  logic       p_ace_q, p_ace_d, d_ace_q, d_ace_d;
  logic [3:0] p_cnt_q, p_cnt_d, d_cnt_q, d_cnt_d;
  logic [1:0] outcome_q, outcome_d;
  logic       outcome_valid_q, outcome_valid_d;
  logic       card_err_q, card_err_d;

  logic       card_legal;
  logic       card_is_ace;
  logic [3:0] card_weight;
  logic [4:0] p_score, d_score;
  logic       p_soft, d_soft, p_bust, d_bust, p_bj, d_bj;
  logic [1:0] result;

  assign card_legal  = (card_value >= 4'd1) && (card_value <= 4'd13);
  assign card_is_ace = (card_value == 4'd1);
  assign card_weight = (card_value > 4'd10) ? 4'd10 : card_value;

  // An Ace is promoted to 11 only while that keeps the hand at or below 21.
  assign p_soft  = p_ace_q && (p_hard_q <= 5'd11);
  assign d_soft  = d_ace_q && (d_hard_q <= 5'd11);
  assign p_score = p_soft ? (p_hard_q + 5'd10) : p_hard_q;
  assign d_score = d_soft ? (d_hard_q + 5'd10) : d_hard_q;
  assign p_bust  = (p_hard_q > 5'd21);
  assign d_bust  = (d_hard_q > 5'd21);
  assign p_bj    = (p_cnt_q == 4'd2) && (p_score == 5'd21);
  assign d_bj    = (d_cnt_q == 4'd2) && (d_score == 5'd21);

  always_comb begin
    result = OUT_PUSH;
    if (p_bust)              result = OUT_DEALER;
    else if (d_bust)         result = OUT_PLAYER;
    else if (p_bj && d_bj)   result = OUT_PUSH;
    else if (p_bj)           result = OUT_PLAYER;
    else if (d_bj)           result = OUT_DEALER;
    else if (p_score > d_score) result = OUT_PLAYER;
    else if (p_score < d_score) result = OUT_DEALER;
  end

  always_comb begin
    state_d         = state_q;
    p_hard_d        = p_hard_q;
    d_hard_d        = d_hard_q;
    p_ace_d         = p_ace_q;
    d_ace_d         = d_ace_q;
    p_cnt_d         = p_cnt_q;
    d_cnt_d         = d_cnt_q;
    outcome_d       = outcome_q;
    outcome_valid_d = outcome_valid_q;
    card_err_d      = card_err_q;

    if (new_round) begin
      state_d         = ST_PLAY;
      p_hard_d        = 5'd0;
      d_hard_d        = 5'd0;
      p_ace_d         = 1'b0;
      d_ace_d         = 1'b0;
      p_cnt_d         = 4'd0;
      d_cnt_d         = 4'd0;
      outcome_d       = OUT_NONE;
      outcome_valid_d = 1'b0;
      card_err_d      = 1'b0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (card_valid) begin
            if (!card_legal) begin
              card_err_d = 1'b1;
            end else if (to_dealer && !d_bust) begin
              d_hard_d = d_hard_q + {1'b0, card_weight};
              d_ace_d  = d_ace_q | card_is_ace;
              d_cnt_d  = (d_cnt_q == 4'd15) ? 4'd15 : d_cnt_q + 4'd1;
            end else if (!to_dealer && !p_bust) begin
              p_hard_d = p_hard_q + {1'b0, card_weight};
              p_ace_d  = p_ace_q | card_is_ace;
              p_cnt_d  = (p_cnt_q == 4'd15) ? 4'd15 : p_cnt_q + 4'd1;
            end
          end
          if (settle) state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          outcome_d       = result;
          outcome_valid_d = 1'b1;
          state_d         = ST_DONE;
        end
        default: begin
          state_d = ST_DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_PLAY;
      p_hard_q        <= 5'd0;
      d_hard_q        <= 5'd0;
      p_ace_q         <= 1'b0;
      d_ace_q         <= 1'b0;
      p_cnt_q         <= 4'd0;
      d_cnt_q         <= 4'd0;
      outcome_q       <= OUT_NONE;
      outcome_valid_q <= 1'b0;
      card_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      p_hard_q        <= p_hard_d;
      d_hard_q        <= d_hard_d;
      p_ace_q         <= p_ace_d;
      d_ace_q         <= d_ace_d;
      p_cnt_q         <= p_cnt_d;
      d_cnt_q         <= d_cnt_d;
      outcome_q       <= outcome_d;
      outcome_valid_q <= outcome_valid_d;
      card_err_q      <= card_err_d;
    end
  end

  assign player_score    = p_score;
  assign dealer_score    = d_score;
  assign player_soft     = p_soft;
  assign dealer_soft     = d_soft;
  assign player_bust     = p_bust;
  assign dealer_bust     = d_bust;
  assign player_bj       = p_bj;
  assign dealer_bj       = d_bj;
  assign player_cards    = p_cnt_q;
  assign dealer_cards    = d_cnt_q;
  assign dealer_must_hit = !d_bust && (d_score < 5'd17);
  assign outcome         = outcome_q;
  assign outcome_valid   = outcome_valid_q;
  assign card_err        = card_err_q;

endmodule

// File: tb/tb_hand_tracker.sv
// tb/tb_hand_tracker.sv - Self-checking bench for hand_tracker: card-list reference model,
// per-cycle compare process, directed scenarios and randomized rounds.
module tb_hand_tracker;

  logic       clk;
  logic       reset;
  logic       card_valid;
  logic [3:0] card_value;
  logic       to_dealer;
  logic       settle;
  logic       new_round;
  logic [4:0] player_score, dealer_score;
  logic       player_soft, dealer_soft, player_bust, dealer_bust, player_bj, dealer_bj;
  logic [3:0] player_cards, dealer_cards;
  logic       dealer_must_hit;
  logic [1:0] outcome;
  logic       outcome_valid;
  logic       card_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;

  // Reference model: hand 0 = player, 1 = dealer, each a list of accepted rank codes.
  int mc[2][32];
  int mn[2];
  bit m_err;
  int m_phase;
  int m_out;
  bit m_ov;

  hand_tracker dut (
    .clk(clk), .reset(reset), .card_valid(card_valid), .card_value(card_value),
    .to_dealer(to_dealer), .settle(settle), .new_round(new_round),
    .player_score(player_score), .dealer_score(dealer_score),
    .player_soft(player_soft), .dealer_soft(dealer_soft),
    .player_bust(player_bust), .dealer_bust(dealer_bust),
    .player_bj(player_bj), .dealer_bj(dealer_bj),
    .player_cards(player_cards), .dealer_cards(dealer_cards),
    .dealer_must_hit(dealer_must_hit), .outcome(outcome),
    .outcome_valid(outcome_valid), .card_err(card_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int m_hard(int h);
    int s = 0;
    for (int i = 0; i < mn[h]; i++) s += (mc[h][i] > 10) ? 10 : mc[h][i];
    return s;
  endfunction

  function automatic bit m_has_ace(int h);
    for (int i = 0; i < mn[h]; i++) if (mc[h][i] == 1) return 1;
    return 0;
  endfunction

  function automatic bit m_soft(int h);
    return m_has_ace(h) && (m_hard(h) + 10 <= 21);
  endfunction

  function automatic int m_score(int h);
    return m_soft(h) ? m_hard(h) + 10 : m_hard(h);
  endfunction

  function automatic bit m_bust(int h);
    return m_hard(h) > 21;
  endfunction

  function automatic bit m_bj(int h);
    return (mn[h] == 2) && (m_score(h) == 21);
  endfunction

  function automatic int m_cnt(int h);
    return (mn[h] > 15) ? 15 : mn[h];
  endfunction

  function automatic int m_result();
    if (m_bust(0)) return 2;
    if (m_bust(1)) return 1;
    if (m_bj(0) && m_bj(1)) return 3;
    if (m_bj(0)) return 1;
    if (m_bj(1)) return 2;
    if (m_score(0) > m_score(1)) return 1;
    if (m_score(0) < m_score(1)) return 2;
    return 3;
  endfunction

  function automatic void m_clear();
    mn[0] = 0; mn[1] = 0; m_err = 0; m_phase = 0; m_out = 0; m_ov = 0;
  endfunction

  function automatic void m_step(bit v, int val, bit dl, bit st, bit nr);
    int h;
    h = dl ? 1 : 0;
    if (nr) begin
      m_clear();
    end else if (m_phase == 0) begin
      if (v) begin
        if (val < 1 || val > 13) m_err = 1;
        else if (!m_bust(h)) begin
          mc[h][mn[h]] = val;
          mn[h]++;
        end
      end
      if (st) m_phase = 1;
    end else if (m_phase == 1) begin
      m_out = m_result();
      m_ov = 1;
      m_phase = 2;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("player_score", 32'(player_score), m_score(0));
      chk("dealer_score", 32'(dealer_score), m_score(1));
      chk("player_soft", 32'(player_soft), 32'(m_soft(0)));
      chk("dealer_soft", 32'(dealer_soft), 32'(m_soft(1)));
      chk("player_bust", 32'(player_bust), 32'(m_bust(0)));
      chk("dealer_bust", 32'(dealer_bust), 32'(m_bust(1)));
      chk("player_bj", 32'(player_bj), 32'(m_bj(0)));
      chk("dealer_bj", 32'(dealer_bj), 32'(m_bj(1)));
      chk("player_cards", 32'(player_cards), m_cnt(0));
      chk("dealer_cards", 32'(dealer_cards), m_cnt(1));
      chk("dealer_must_hit", 32'(dealer_must_hit), 32'(!m_bust(1) && m_score(1) < 17));
      chk("outcome", 32'(outcome), m_out);
      chk("outcome_valid", 32'(outcome_valid), 32'(m_ov));
      chk("card_err", 32'(card_err), 32'(m_err));
    end
  end

  task automatic cyc(input bit v, input int val, input bit dl, input bit st, input bit nr);
    card_valid = v;
    card_value = 4'(val);
    to_dealer  = dl;
    settle     = st;
    new_round  = nr;
    @(posedge clk);
    m_step(v, val, dl, st, nr);
    #1;
    card_valid = 0;
    settle     = 0;
    new_round  = 0;
  endtask

  task automatic card(input bit dl, input int val);
    cyc(1, val, dl, 0, 0);
  endtask

  task automatic fresh();
    cyc(0, 0, 0, 0, 1);
  endtask

  initial begin
    bit v, dl, st, nr;
    int val;
    reset = 0; card_valid = 0; card_value = 0; to_dealer = 0; settle = 0; new_round = 0;
    m_clear();
    cmp_en = 1;
    #2;
    chk("rst_player_score", 32'(player_score), 0);
    chk("rst_dealer_cards", 32'(dealer_cards), 0);
    chk("rst_must_hit", 32'(dealer_must_hit), 1);
    chk("rst_outcome_valid", 32'(outcome_valid), 0);
    #10 reset = 1;
    @(posedge clk); #1;

    fresh(); card(0, 1); card(0, 13);
    chk("nat_score", 32'(player_score), 21);
    chk("nat_soft", 32'(player_soft), 1);
    chk("nat_bj", 32'(player_bj), 1);
    chk("nat_cards", 32'(player_cards), 2);

    fresh(); card(0, 1); card(0, 1); card(0, 9);
    chk("aa9_score", 32'(player_score), 21);
    chk("aa9_soft", 32'(player_soft), 1);
    chk("aa9_bj", 32'(player_bj), 0);
    card(0, 5);
    chk("aa95_score", 32'(player_score), 16);
    chk("aa95_soft", 32'(player_soft), 0);

    fresh(); card(0, 10); card(0, 6); card(0, 12);
    chk("bust_score", 32'(player_score), 26);
    chk("bust_flag", 32'(player_bust), 1);
    card(0, 3);
    chk("drop_score", 32'(player_score), 26);
    chk("drop_cards", 32'(player_cards), 3);

    fresh(); card(1, 1); card(1, 6);
    chk("s17_score", 32'(dealer_score), 17);
    chk("s17_soft", 32'(dealer_soft), 1);
    chk("s17_hit", 32'(dealer_must_hit), 0);
    fresh(); card(1, 10); card(1, 6);
    chk("h16_score", 32'(dealer_score), 16);
    chk("h16_hit", 32'(dealer_must_hit), 1);

    fresh(); card(0, 10); card(0, 9); card(1, 10); card(1, 8);
    cyc(0, 0, 0, 1, 0);
    chk("settle_pending", 32'(outcome_valid), 0);
    cyc(0, 0, 0, 0, 0);
    chk("win_outcome", 32'(outcome), 1);
    chk("win_valid", 32'(outcome_valid), 1);

    fresh(); card(0, 10); card(0, 11); card(1, 10);
    cyc(1, 13, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("push_dscore", 32'(dealer_score), 20);
    chk("push_outcome", 32'(outcome), 3);
    card(0, 14);
    chk("done_ignore_err", 32'(card_err), 0);
    chk("done_hold", 32'(outcome), 3);

    fresh(); card(0, 10); card(0, 10); card(0, 5); card(1, 10); card(1, 10); card(1, 5);
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0);
    chk("bb_outcome", 32'(outcome), 2);

    fresh(); card(0, 10);
    cyc(1, 5, 0, 0, 1);
    chk("nr_cards", 32'(player_cards), 0);
    chk("nr_score", 32'(player_score), 0);
    chk("nr_outcome", 32'(outcome), 0);

    fresh(); card(0, 7); card(0, 14);
    chk("ill_err", 32'(card_err), 1);
    chk("ill_score", 32'(player_score), 7);
    chk("ill_cards", 32'(player_cards), 1);

    fresh(); card(0, 10); card(1, 9);
    #2 reset = 0;
    m_clear();
    #1;
    chk("mid_rst_score", 32'(player_score), 0);
    chk("mid_rst_dcards", 32'(dealer_cards), 0);
    chk("mid_rst_hit", 32'(dealer_must_hit), 1);
    #3 reset = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 3000; i++) begin
      nr  = (m_phase == 2) ? ($urandom % 4 == 0) : ($urandom % 60 == 0);
      st  = ($urandom % 15 == 0);
      v   = $urandom % 2;
      dl  = $urandom % 2;
      val = ($urandom % 12 == 0) ? $urandom_range(0, 15) : $urandom_range(1, 13);
      cyc(v, val, dl, st, nr);
    end

    @(negedge clk);
    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hand_tracker.md
# hand_tracker

Downstream consumer of the card dealer in the Blackjack design. Accepts each dealt card (`card_value` / `card_valid` pulse) and routes it into the player or dealer hand. Maintains running totals with soft-ace handling, plus bust, blackjack and dealer-hit status. On request, settles the round into a registered win/lose/push outcome for the display and game-control logic.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `card_valid`  in  1  single-cycle pulse: `card_value` is valid this cycle.
- `card_value`  in  4  rank code: 1 = Ace, 2–10 = pip value, 11–13 = J/Q/K; 0, 14 and 15 are illegal.
- `to_dealer`  in  1  sampled with `card_valid`: 1 = dealer hand, 0 = player hand.
- `settle`  in  1  pulse: end the round and compute the outcome.
- `new_round`  in  1  pulse: clear both hands and return to PLAY.
- `player_score`, `dealer_score`  out  5 each  best hand total.
- `player_soft`, `dealer_soft`  out  1 each  an Ace is currently counted as 11.
- `player_bust`, `dealer_bust`  out  1 each  hard total > 21.
- `player_bj`, `dealer_bj`  out  1 each  natural: exactly 2 cards and score 21.
- `player_cards`, `dealer_cards`  out  4 each  cards accepted into the hand, saturating at 15.
- `dealer_must_hit`  out  1  dealer score < 17 and dealer not bust.
- `outcome`  out  2  0 = none, 1 = player wins, 2 = dealer wins, 3 = push.
- `outcome_valid`  out  1  high while `outcome` is final.
- `card_err`  out  1  sticky: an illegal `card_value` was seen.

## Operation
- **State machine.** PLAY → SETTLE on `settle`. SETTLE → DONE unconditionally after 1 cycle. DONE holds until `new_round`. `new_round` in any state → PLAY with both hands cleared.
- **Per-hand registers.** `hard` (5 bits, Aces counted as 1), `ace` (1 bit), `cnt` (4 bits).
- **Card weight.** 1 → 1 and sets `ace`. 2–10 → face value. 11–13 → 10.
- **Card acceptance.** A card is accepted only in PLAY, with `card_valid` = 1, a legal code, and the target hand not already bust.
- **Accepted card.** Adds the weight to `hard` and increments `cnt`, saturating at 15.
- **Card to a bust hand.** Dropped: no change to `hard` or `cnt`.
- **Illegal code.** Dropped and sets `card_err`. `card_err` clears only on reset or `new_round`.
- **`card_valid` in SETTLE or DONE.** Ignored, no error.
- **Score.** score = `hard` + 10 if `ace` and `hard` ≤ 11, otherwise `hard`. soft = the same condition. bust = `hard` > 21.
- **Width.** Maximum `hard` is 21 + 10 = 31, so it fits in 5 bits and never wraps. `score` ≤ 31.
- **Dealer rule.** Dealer stands on all 17s, soft 17 included. `dealer_must_hit` = !`dealer_bust` && `dealer_score` < 17.
- **Outcome priority** (computed in SETTLE):
  1. player bust → 2
  2. dealer bust → 1
  3. both naturals → 3
  4. player natural only → 1
  5. dealer natural only → 2
  6. otherwise compare scores: higher wins, equal → 3
- **Simultaneous events.**
  - `new_round` beats `card_valid` and `settle` in the same cycle; the card is dropped.
  - `settle` together with `card_valid` in PLAY: the card is accepted, and SETTLE evaluates the updated hands.
- **Reset mid-round.** Immediately clears everything, asynchronously.

## Timing
- **Reset values.**
  - All scores, counts, flags, `outcome`, `outcome_valid` and `card_err` are 0.
  - State is PLAY.
  - `dealer_must_hit` is 1, since the dealer score is 0.
- **Output paths.** All outputs are functions of registers only; there is no combinational path from input to output.
- **Card latency.** For a card accepted at edge N, scores, flags and counts reflect it from edge N onward (visible in the cycle after the pulse).
- **Settle latency.** `settle` sampled at edge N → SETTLE. `outcome` and `outcome_valid` are registered at edge N+1 and held until `new_round`.
- **Clear latency.** `new_round` at edge N → all hand outputs, `outcome` and `outcome_valid` are 0 after edge N.
- **Back-to-back cards.** `card_valid` may be high on consecutive cycles; each cycle is one card.

## Test plan
- **Player natural.** Player Ace then K → `player_score` = 21, `player_soft` = 1, `player_bj` = 1, `player_cards` = 2.
- **Soft to hard conversion.** Player A, A, 9 → score 21, soft = 1, bj = 0. A further card 5 → score 16, soft = 0.
- **Bust and drop.** Player 10, 6, Q → score 26, bust = 1. A further card 3 is dropped: score stays 26, `player_cards` stays 3.
- **Dealer stand rule.** Dealer A, 6 → score 17, soft = 1, `dealer_must_hit` = 0. Dealer 10, 6 → score 16, `must_hit` = 1.
- **Settle outcomes.**
  - Player 10, 9 vs dealer 10, 8, then `settle` → `outcome` = 1, `outcome_valid` = 1 two edges later.
  - Player 20 vs dealer 20 → `outcome` = 3.
  - Player bust vs dealer bust → `outcome` = 2.
- **Corner cases.**
  - `new_round` concurrent with `card_valid` → all cleared, card dropped.
  - `card_value` = 14 → `card_err` = 1 and totals unchanged.
  - Reset asserted mid-hand → all outputs at reset values with no clock edge needed.
